// File: rtl/csa_limb_sequencer_if.sv
// csa_limb_sequencer_if: request, shared-adder and response signals of csa_limb_sequencer.
// rsp_ovf exists only when CSA_SEQ_OVF_EN is defined.
interface csa_limb_sequencer_if #(
    parameter int LIMBS = 4,
    parameter int NREQ  = 2
);
    localparam int W   = 16 * LIMBS;
    localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [15:0]       add_a;
    logic [15:0]       add_b;
    logic              add_cin;
    logic [16:0]       add_sum;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
`ifdef CSA_SEQ_OVF_EN
    logic              rsp_ovf;
`endif
    modport master (
        output req_valid, req_a, req_b, req_cin, add_sum, rsp_ready,
        input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
`ifdef CSA_SEQ_OVF_EN
        , input rsp_ovf
`endif
    );
    modport slave (
        input  req_valid, req_a, req_b, req_cin, add_sum, rsp_ready,
        output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
`ifdef CSA_SEQ_OVF_EN
        , output rsp_ovf
`endif
    );
endinterface

// File: rtl/csa_limb_sequencer.sv
// csa_limb_sequencer: round-robin multi-precision adder sharing one 16-bit external adder.
// Define CSA_SEQ_OVF_EN to add the rsp_ovf signed-overflow output.
module csa_limb_sequencer #(
    parameter int LIMBS = 4,
    parameter int NREQ  = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    csa_limb_sequencer_if.slave bus
);
    localparam int W   = 16 * LIMBS;
    localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int KW  = LIMBS > 1 ? $clog2(LIMBS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state_q;
    logic [W-1:0]   a_q, b_q, sum_q;
    logic [KW-1:0]  k_q;
    logic [IDW-1:0] ptr_q, id_q, grant, idx, ptr_d;
    logic           carry_q, cout_q, rsp_valid_q, found;
`ifdef CSA_SEQ_OVF_EN
    logic           ovf_q;
    assign bus.rsp_ovf = ovf_q;
`endif
    // first valid requester at or above ptr_q, wrapping
    always_comb begin
        grant = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            idx = IDW'((int'(ptr_q) + j) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
        ptr_d = IDW'((int'(grant) + 1) % NREQ);
    end
    assign bus.req_ready = (state_q == IDLE && found) ? NREQ'(1) << grant : '0;
    assign bus.add_a     = state_q == RUN ? a_q[16*k_q +: 16] : '0;
    assign bus.add_b     = state_q == RUN ? b_q[16*k_q +: 16] : '0;
    assign bus.add_cin   = state_q == RUN && carry_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
`ifdef CSA_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    a_q     <= bus.req_a[grant*W +: W];
                    b_q     <= bus.req_b[grant*W +: W];
                    carry_q <= bus.req_cin[grant];
                    id_q    <= grant;
                    ptr_q   <= ptr_d;
                    k_q     <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    sum_q[16*k_q +: 16] <= bus.add_sum[15:0];
                    carry_q             <= bus.add_sum[16];
                    k_q                 <= k_q + 1'b1;
                    if (k_q == KW'(LIMBS - 1)) begin
                        k_q         <= '0;
                        cout_q      <= bus.add_sum[16];
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef CSA_SEQ_OVF_EN
                        // carry into the sign bit recovered from the sum bit and its operand bits
                        ovf_q       <= bus.add_sum[15] ^ a_q[W-1] ^ b_q[W-1] ^ bus.add_sum[16];
`endif
                    end
                end
                DONE: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/csa_limb_sequencer.md
# csa_limb_sequencer

Multi-precision add controller that shares one external 16-bit conditional-sum adder (17-bit result, carry-in) between NREQ requesters. It accepts 16*LIMBS-bit operand pairs over a valid/ready handshake and arbitrates round-robin between requesters. It streams the operands through the adder one 16-bit limb per cycle, LSB limb first, chaining the carry. It then returns the full sum and carry-out on a valid/ready response port. It sits between the adder datapath and any client needing wide additions.

## Interface
- LIMBS, default 4: limbs per operand; W = 16*LIMBS (64 by default); legal range 1..8.
- NREQ, default 2: requester count; legal range 1..4.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*W  operand A; requester i at [i*W +: W].
- req_b  in  NREQ*W  operand B, same packing.
- req_cin  in  NREQ  carry-in per requester.
- add_a  out  16  limb of A to adder.
- add_b  out  16  limb of B to adder.
- add_cin  out  1  carry into adder.
- add_sum  in  17  combinational adder result {cout, sum[15:0]}, valid in the same cycle.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  clog2(NREQ) (min 1)  index of the requester that owns the result.
- rsp_sum  out  W  sum.
- rsp_cout  out  1  carry out of the top limb.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: grant = first requester with req_valid set, searching from priority pointer ptr upward with wrap. req_ready[grant] = 1, combinational from req_valid. No valid requests -> req_ready all 0.
- Accept (req_valid & req_ready): capture A, B, cin, id; limb counter k = 0; carry = cin; ptr = grant+1 mod NREQ; go to RUN.
- RUN: add_a = A[16k+:16], add_b = B[16k+:16], add_cin = carry. Each edge: store add_sum[15:0] into sum limb k; carry = add_sum[16]; k++. After limb LIMBS-1 go to DONE.
- Outside RUN, add_a, add_b and add_cin drive 0.
- DONE: rsp_valid = 1; rsp_sum, rsp_cout and rsp_id are held stable until rsp_ready. On handshake go to IDLE.
- A requester dropping req_valid before accept is legal. Operands are sampled only at accept, so later changes to req_a/req_b have no effect.
- Reset: ptr = 0, state = IDLE, k = 0, carry = 0. Outputs: req_ready 0, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, add_* 0. Reset mid-RUN or mid-DONE discards the operation without emitting a response.

## Timing
- Accept at edge T. RUN occupies cycles T..T+LIMBS-1. rsp_valid rises after edge T+LIMBS, so latency is LIMBS+1 cycles from the accept cycle.
- With rsp_ready held high, the handshake completes in the first DONE cycle. The next accept is possible in the following cycle, giving a minimum request period of LIMBS+2 cycles.
- Backpressure: DONE persists indefinitely; req_ready stays 0 for the whole of RUN and DONE.
- LIMBS=1: a single RUN cycle; the same rules apply.

## Configuration
- CSA_SEQ_OVF_EN defined: adds output port rsp_ovf (1 bit). rsp_ovf is two's-complement overflow of the top limb: carry into bit W-1 XOR rsp_cout. It is captured on the final RUN edge, held through DONE, and resets to 0.
- Not defined: port rsp_ovf and its logic are absent; all other behaviour is identical.

## Test plan
- Single add, LIMBS=4, requester 0: A=0xFFFF_FFFF_FFFF_FFFF, B=1, cin=0 -> rsp_sum=0, rsp_cout=1, rsp_id=0. rsp_valid appears 5 cycles after accept. add_cin must read 1 in RUN limbs 1..3.
- Carry-in only: A=0x0000_0000_0000_FFFF, B=0, cin=1 -> rsp_sum=0x0000_0000_0001_0000, rsp_cout=0.
- Arbitration: both requesters valid continuously from reset -> grants alternate 0,1,0,1. rsp_id matches each response, and each result equals its own operands' sum.
- Backpressure: rsp_ready low for 10 cycles in DONE -> rsp_sum, rsp_cout and rsp_id remain stable and req_ready stays 0. The result is released on the first cycle with rsp_ready high.
- Reset mid-RUN (assert rst_n=0 at k=2) -> no response emitted and all outputs reset immediately. The next request completes correctly, with ptr restarted at 0.
- With CSA_SEQ_OVF_EN: A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> rsp_ovf=1, rsp_cout=0. A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> rsp_ovf=0, rsp_cout=1.
